// File: rtl/echo_medidor.sv
// Ultrasonic echo width meter: after a start request, times the echo high pulse
// and reports it in whole centimetres, or flags a timeout if no complete echo arrives.
module echo_medidor #(
  parameter int CICLOS_POR_CM  = 2900,
  parameter int TIMEOUT_CICLOS = 1500000,
  parameter int MAX_CM         = 400,
  parameter int DIST_W         = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              echo,
  output logic [DIST_W-1:0] distancia_cm,
  output logic              valid,
  output logic              timeout,
  output logic              busy
);

  localparam int PRESC_W = (CICLOS_POR_CM > 1) ? $clog2(CICLOS_POR_CM) : 1;
  localparam int TMO_W   = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CICLOS_POR_CM - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CICLOS - 1);
  localparam logic [DIST_W-1:0]  CM_MAX     = DIST_W'(MAX_CM);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ECHO = 2'd1,
    MEASURE   = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic echo_s1_q, echo_s2_q, echo_s3_q;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [DIST_W-1:0]  cm_q, cm_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [DIST_W-1:0]  dist_q, dist_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;

  logic echo_rise;
  logic echo_fall;
  logic tmo_last;
  logic presc_wrap;

  always_comb begin
    echo_rise  = echo_s2_q & ~echo_s3_q;
    echo_fall  = ~echo_s2_q & echo_s3_q;
    tmo_last   = (tmo_q == TMO_LAST);
    presc_wrap = (presc_q == PRESC_LAST);

    state_d   = state_q;
    presc_d   = presc_q;
    cm_d      = cm_q;
    tmo_d     = tmo_q;
    dist_d    = dist_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_ECHO;
          tmo_d   = '0;
        end
      end

      WAIT_ECHO: begin
        tmo_d = tmo_q + 1'b1;
        // A rise landing on the last window cycle cannot complete an echo in time.
        if (tmo_last) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (echo_rise) begin
          state_d = MEASURE;
          presc_d = '0;
          cm_d    = '0;
        end
      end

      MEASURE: begin
        tmo_d = tmo_q + 1'b1;
        // The falling-edge cycle itself still counts toward the pulse width.
        if (presc_wrap) begin
          presc_d = '0;
          if (cm_q < CM_MAX) begin
            cm_d = cm_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end

        if (echo_fall) begin
          state_d = DONE;
          valid_d = 1'b1;
          dist_d  = cm_d;
        end else if (tmo_last) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_s3_q <= 1'b0;
      presc_q   <= '0;
      cm_q      <= '0;
      tmo_q     <= '0;
      dist_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
      presc_q   <= presc_d;
      cm_q      <= cm_d;
      tmo_q     <= tmo_d;
      dist_q    <= dist_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
    end
  end

  assign distancia_cm = dist_q;
  assign valid        = valid_q;
  assign timeout      = timeout_q;
  assign busy         = busy_q;

endmodule
